cache_tag_array: RTL and testbench

Multi-way tag/valid/dirty store for the L1 caches, generalising the single-way 64-entry tag RAM to WAYS ways, SETS sets and TAG_W-bit tags. It adds per-way write, dirty tracking, registered hit compare and a multi-cycle flush engine. It sits between the cache controller FSM and the data arrays: lookup in cycle N, hit vector in cycle N+1.

---
 rtl/cache_tag_array_pkg.sv | 14 +
 rtl/cache_tag_array_tag_way_ram.sv | 24 ++
 rtl/cache_tag_array.sv | 181 ++++++++++++++++++
 tb/tb_cache_tag_array.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/cache_tag_array_pkg.sv
// Shared defaults and flush-engine state encoding for the multi-way cache tag store.
package cache_tag_array_pkg;

  localparam int DEF_WAYS  = 2;
  localparam int DEF_SETS  = 64;
  localparam int DEF_TAG_W = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } flush_st_t;

endpackage

// File: rtl/cache_tag_array_tag_way_ram.sv
// One way of tag storage: SETS x TAG_W array, synchronous write, registered read.
// A read and write to the same set in one cycle returns the pre-write tag.
module tag_way_ram #(
  parameter int SETS  = 64,
  parameter int TAG_W = 20,
  parameter int SET_W = $clog2(SETS)
) (
  input  logic             clka,
  input  logic             wr_en,
  input  logic [SET_W-1:0] wr_set,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             rd_en,
  input  logic [SET_W-1:0] rd_set,
  output logic [TAG_W-1:0] rd_tag
);

  logic [TAG_W-1:0] mem [SETS];

  always_ff @(posedge clka) begin
    if (wr_en) mem[wr_set] <= wr_tag;
    if (rd_en) rd_tag <= mem[rd_set];
  end

endmodule

// File: rtl/cache_tag_array.sv
// Multi-way tag/valid/dirty store with 1-cycle lookup and a SETS+2 cycle flush engine.
// Optional same-set write-to-lookup forwarding is enabled by defining TAG_BYPASS_EN.
module cache_tag_array
  import cache_tag_array_pkg::*;
#(
  parameter int WAYS  = DEF_WAYS,
  parameter int SETS  = DEF_SETS,
  parameter int TAG_W = DEF_TAG_W,
  parameter int SET_W = $clog2(SETS)
) (
  input  logic                  clka,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [WAYS-1:0]       wr_way,
  input  logic [SET_W-1:0]      wr_set,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic                  wr_valid,
  input  logic                  wr_dirty,
  input  logic                  rd_en,
  input  logic [SET_W-1:0]      rd_set,
  input  logic [TAG_W-1:0]      rd_tag,
  output logic [WAYS*TAG_W-1:0] rd_tags,
  output logic [WAYS-1:0]       rd_valid,
  output logic [WAYS-1:0]       rd_dirty,
  output logic [WAYS-1:0]       rd_hit,
  output logic                  rd_any_hit,
  input  logic                  flush_req,
  output logic                  ready,
  output logic                  flush_done
);

  localparam logic [SET_W-1:0] LAST_SET = SET_W'(SETS - 1);

  flush_st_t        state_q, state_d;
  logic [SET_W-1:0] cnt_q, cnt_d;

  logic [WAYS-1:0]  v_mem [SETS];
  logic [WAYS-1:0]  d_mem [SETS];
  logic [TAG_W-1:0] ram_tag [WAYS];
  logic [TAG_W-1:0] tag_eff [WAYS];
  logic [WAYS-1:0]  lk_valid, lk_dirty;
  logic [WAYS-1:0]  valid_q, dirty_q;
  logic [TAG_W-1:0] cmp_q;
  logic             wr_ok;

  assign wr_ok = wr_en & ready;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    tag_way_ram #(.SETS(SETS), .TAG_W(TAG_W), .SET_W(SET_W)) u_ram (
      .clka   (clka),
      .wr_en  (wr_ok & wr_way[w]),
      .wr_set (wr_set),
      .wr_tag (wr_tag),
      .rd_en  (rd_en),
      .rd_set (rd_set),
      .rd_tag (ram_tag[w])
    );
  end

  // Flush engine: state register, next-state logic, outputs.
  always_ff @(posedge clka) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (flush_req) begin
        state_d = WALK;
        cnt_d   = '0;
      end
      WALK: if (cnt_q == LAST_SET) state_d = DONE;
            else cnt_d = cnt_q + SET_W'(1);
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready      = (state_q == IDLE);
    flush_done = (state_q == DONE);
  end

  always_ff @(posedge clka) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        v_mem[s] <= '0;
        d_mem[s] <= '0;
      end
    end else if (state_q == WALK) begin
      v_mem[cnt_q] <= '0;
      d_mem[cnt_q] <= '0;
    end else if (wr_ok) begin
      for (int w = 0; w < WAYS; w++) begin
        if (wr_way[w]) begin
          v_mem[wr_set][w] <= wr_valid;
          d_mem[wr_set][w] <= wr_dirty;
        end
      end
    end
  end

`ifdef TAG_BYPASS_EN
  logic             byp;
  logic [WAYS-1:0]  fwd_q;
  logic [TAG_W-1:0] fwd_tag_q;

  assign byp = wr_ok && rd_en && (wr_set == rd_set);

  always_ff @(posedge clka) begin
    if (!rst_n) begin
      fwd_q     <= '0;
      fwd_tag_q <= '0;
    end else if (rd_en) begin
      fwd_q     <= byp ? wr_way : '0;
      fwd_tag_q <= wr_tag;
    end
  end

  always_comb begin
    for (int w = 0; w < WAYS; w++) tag_eff[w] = fwd_q[w] ? fwd_tag_q : ram_tag[w];
  end
`else
  always_comb begin
    for (int w = 0; w < WAYS; w++) tag_eff[w] = ram_tag[w];
  end
`endif

  always_comb begin
    lk_valid = v_mem[rd_set];
    lk_dirty = d_mem[rd_set];
`ifdef TAG_BYPASS_EN
    for (int w = 0; w < WAYS; w++) begin
      if (byp && wr_way[w]) begin
        lk_valid[w] = wr_valid;
        lk_dirty[w] = wr_dirty;
      end
    end
`endif
    // A lookup while the flush engine is busy reports nothing.
    if (!ready) begin
      lk_valid = '0;
      lk_dirty = '0;
    end
  end

  always_ff @(posedge clka) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
      cmp_q   <= '0;
    end else if (rd_en) begin
      valid_q <= lk_valid;
      dirty_q <= lk_dirty & lk_valid;
      cmp_q   <= rd_tag;
    end
  end

  always_comb begin
    rd_tags = '0;
    rd_hit  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w]) rd_tags[w*TAG_W +: TAG_W] = tag_eff[w];
      rd_hit[w] = valid_q[w] && (tag_eff[w] == cmp_q);
    end
    rd_valid   = valid_q;
    rd_dirty   = dirty_q;
    rd_any_hit = |rd_hit;
  end

endmodule

// File: tb/tb_cache_tag_array.sv
// Directed bench for cache_tag_array (WAYS=2, SETS=64, TAG_W=20): vector table plus flush/reset sequences.
module tb_cache_tag_array;

`ifdef TAG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clka = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [1:0]  wr_way;
  logic [5:0]  wr_set;
  logic [19:0] wr_tag;
  logic        wr_valid, wr_dirty;
  logic        rd_en;
  logic [5:0]  rd_set;
  logic [19:0] rd_tag;
  logic [39:0] rd_tags;
  logic [1:0]  rd_valid, rd_dirty, rd_hit;
  logic        rd_any_hit;
  logic        flush_req, ready, flush_done;

  int n_cmp = 0;
  int n_bad = 0;

  cache_tag_array dut (
    .clka(clka), .rst_n(rst_n),
    .wr_en(wr_en), .wr_way(wr_way), .wr_set(wr_set), .wr_tag(wr_tag),
    .wr_valid(wr_valid), .wr_dirty(wr_dirty),
    .rd_en(rd_en), .rd_set(rd_set), .rd_tag(rd_tag),
    .rd_tags(rd_tags), .rd_valid(rd_valid), .rd_dirty(rd_dirty),
    .rd_hit(rd_hit), .rd_any_hit(rd_any_hit),
    .flush_req(flush_req), .ready(ready), .flush_done(flush_done)
  );

  always #5 clka = ~clka;

  typedef struct {
    logic        we;
    logic [1:0]  way;
    logic [5:0]  wset;
    logic [19:0] wtag;
    logic        wv, wd;
    logic        re;
    logic [5:0]  rset;
    logic [19:0] rtag;
    logic [1:0]  ev, ed, eh;
    logic [19:0] et1, et0;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of write/lookup, then sample #1 after the edge.
  task automatic op(input logic we, input logic [1:0] way, input logic [5:0] wset,
                    input logic [19:0] wtag, input logic wv, input logic wd,
                    input logic re, input logic [5:0] rset, input logic [19:0] rtag);
    wr_en = we; wr_way = way; wr_set = wset; wr_tag = wtag; wr_valid = wv; wr_dirty = wd;
    rd_en = re; rd_set = rset; rd_tag = rtag;
    @(posedge clka); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic chk_out(input string name, input logic [1:0] ev, input logic [1:0] ed,
                         input logic [1:0] eh, input logic [19:0] et1, input logic [19:0] et0);
    chk({name, ".valid"}, 64'(rd_valid), 64'(ev));
    chk({name, ".dirty"}, 64'(rd_dirty), 64'(ed));
    chk({name, ".hit"},   64'(rd_hit),   64'(eh));
    chk({name, ".any"},   64'(rd_any_hit), 64'(|eh));
    chk({name, ".tags"},  64'(rd_tags),  64'({et1, et0}));
  endtask

  initial begin
    int cyc, done_cnt, done_at, bad_ev;

    rst_n = 1'b0; flush_req = 1'b0;
    wr_en = 1'b0; wr_way = '0; wr_set = '0; wr_tag = '0; wr_valid = 1'b0; wr_dirty = 1'b0;
    rd_en = 1'b0; rd_set = '0; rd_tag = '0;
    repeat (2) @(posedge clka);
    #1 rst_n = 1'b1;

    chk("rst.ready", 64'(ready), 64'd1);
    chk("rst.done", 64'(flush_done), 64'd0);
    chk_out("rst", 2'b00, 2'b00, 2'b00, 20'h0, 20'h0);

    //        we  way    wset wtag      v  d   re  rset rtag      ev ed eh  et1 et0
    vt[0]  = '{0, 2'b00, 0,  20'h0,     0, 0,  1,  5,  20'h00000, 2'b00, 2'b00, 2'b00, 20'h0, 20'h0};
    vt[1]  = '{1, 2'b10, 5,  20'hABCDE, 1, 1,  0,  0,  20'h0,     2'b00, 2'b00, 2'b00, 20'h0, 20'h0};
    vt[2]  = '{0, 2'b00, 0,  20'h0,     0, 0,  1,  5,  20'hABCDE, 2'b10, 2'b10, 2'b10, 20'hABCDE, 20'h0};
    vt[3]  = '{0, 2'b00, 0,  20'h0,     0, 0,  1,  5,  20'hABCDF, 2'b10, 2'b10, 2'b00, 20'hABCDE, 20'h0};
    vt[4]  = '{1, 2'b01, 9,  20'h12345, 1, 0,  1,  9,  20'h12345,
               BYP ? 2'b01 : 2'b00, 2'b00, BYP ? 2'b01 : 2'b00, 20'h0, BYP ? 20'h12345 : 20'h0};
    vt[5]  = '{0, 2'b00, 0,  20'h0,     0, 0,  1,  9,  20'h12345, 2'b01, 2'b00, 2'b01, 20'h0, 20'h12345};
    vt[6]  = '{0, 2'b00, 0,  20'h0,     0, 0,  0,  5,  20'hABCDE, 2'b01, 2'b00, 2'b01, 20'h0, 20'h12345};
    vt[7]  = '{1, 2'b01, 3,  20'h55555, 0, 1,  0,  0,  20'h0,     2'b01, 2'b00, 2'b01, 20'h0, 20'h12345};
    vt[8]  = '{0, 2'b00, 0,  20'h0,     0, 0,  1,  3,  20'h55555, 2'b00, 2'b00, 2'b00, 20'h0, 20'h0};
    vt[9]  = '{1, 2'b11, 7,  20'h0F0F0, 1, 0,  0,  0,  20'h0,     2'b00, 2'b00, 2'b00, 20'h0, 20'h0};
    vt[10] = '{0, 2'b00, 0,  20'h0,     0, 0,  1,  7,  20'h0F0F0, 2'b11, 2'b00, 2'b11, 20'h0F0F0, 20'h0F0F0};
    vt[11] = '{0, 2'b00, 0,  20'h0,     0, 0,  1,  5,  20'hABCDE, 2'b10, 2'b10, 2'b10, 20'hABCDE, 20'h0};
    vt[12] = '{1, 2'b01, 5,  20'h11111, 1, 0,  1,  5,  20'hABCDE,
               BYP ? 2'b11 : 2'b10, 2'b10, 2'b10, 20'hABCDE, BYP ? 20'h11111 : 20'h0};
    vt[13] = '{0, 2'b00, 0,  20'h0,     0, 0,  1,  5,  20'h11111, 2'b11, 2'b10, 2'b01, 20'hABCDE, 20'h11111};

    for (int i = 0; i < 14; i++) begin
      op(vt[i].we, vt[i].way, vt[i].wset, vt[i].wtag, vt[i].wv, vt[i].wd,
         vt[i].re, vt[i].rset, vt[i].rtag);
      chk_out($sformatf("vec%0d", i), vt[i].ev, vt[i].ed, vt[i].eh, vt[i].et1, vt[i].et0);
    end

    // Flush: fill sets 0 and 63, then walk; a write and a lookup are issued mid-flush.
    op(1, 2'b11, 0,  20'hAAAAA, 1, 1, 0, 0, 20'h0);
    op(1, 2'b11, 63, 20'hAAAAA, 1, 1, 0, 0, 20'h0);
    op(0, 2'b00, 0,  20'h0,     0, 0, 1, 63, 20'hAAAAA);
    chk_out("fill63", 2'b11, 2'b11, 2'b11, 20'hAAAAA, 20'hAAAAA);

    flush_req = 1'b1;
    @(posedge clka); #1;
    flush_req = 1'b0;
    cyc = 0; done_cnt = 0; done_at = 0;
    while (!ready && cyc < 200) begin
      cyc++;
      if (flush_done) begin done_cnt++; done_at = cyc; end
      if (cyc == 4) chk("flush.rd_busy", 64'(rd_valid), 64'd0);
      rd_en = (cyc == 3); rd_set = 6'd63; rd_tag = 20'hAAAAA;
      wr_en = (cyc == 10); wr_way = 2'b11; wr_set = 6'd2; wr_tag = 20'h77777;
      wr_valid = 1'b1; wr_dirty = 1'b1;
      @(posedge clka); #1;
    end
    wr_en = 1'b0; rd_en = 1'b0;
    chk("flush.busy_cycles", 64'(cyc), 64'd65);
    chk("flush.done_at", 64'(done_at), 64'd65);
    chk("flush.done_count", 64'(done_cnt), 64'd1);
    chk("flush.ready_after", 64'(ready), 64'd1);
    op(0, 2'b00, 0, 20'h0, 0, 0, 1, 0,  20'hAAAAA); chk_out("post.set0",  2'b00, 2'b00, 2'b00, 20'h0, 20'h0);
    op(0, 2'b00, 0, 20'h0, 0, 0, 1, 63, 20'hAAAAA); chk_out("post.set63", 2'b00, 2'b00, 2'b00, 20'h0, 20'h0);
    op(0, 2'b00, 0, 20'h0, 0, 0, 1, 2,  20'h77777); chk_out("post.set2",  2'b00, 2'b00, 2'b00, 20'h0, 20'h0);

    // Reset during the walk at counter 30 aborts the flush.
    op(1, 2'b11, 50, 20'hBBBBB, 1, 1, 0, 0, 20'h0);
    flush_req = 1'b1;
    @(posedge clka); #1;
    flush_req = 1'b0;
    repeat (30) @(posedge clka);
    #1 rst_n = 1'b0;
    @(posedge clka); #1;
    rst_n = 1'b1;
    chk("rstwalk.ready", 64'(ready), 64'd1);
    chk("rstwalk.done", 64'(flush_done), 64'd0);
    bad_ev = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clka); #1;
      if (flush_done || !ready) bad_ev++;
    end
    chk("rstwalk.quiet", 64'(bad_ev), 64'd0);
    op(0, 2'b00, 0, 20'h0, 0, 0, 1, 50, 20'hBBBBB); chk_out("rstwalk.set50", 2'b00, 2'b00, 2'b00, 20'h0, 20'h0);
    op(0, 2'b00, 0, 20'h0, 0, 0, 1, 5,  20'hABCDE); chk_out("rstwalk.set5",  2'b00, 2'b00, 2'b00, 20'h0, 20'h0);
    op(1, 2'b10, 50, 20'hCCCCC, 1, 0, 0, 0, 20'h0);
    op(0, 2'b00, 0, 20'h0, 0, 0, 1, 50, 20'hCCCCC); chk_out("rstwalk.rewrite", 2'b10, 2'b00, 2'b10, 20'hCCCCC, 20'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
